// File: rtl/dbg_uart_tx_pkg.sv
// Shared UART frame constants and serializer state encoding for the debug UART path.
package dbg_uart_tx_pkg;

    localparam logic        START_BIT = 1'b0;
    localparam logic        STOP_BIT  = 1'b1;
    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

endpackage

// File: rtl/dbg_fifo.sv
// Small synchronous FIFO for debug words. A push into a full FIFO is still accepted when a
// pop happens on the same edge; the pop then returns the old head.
module dbg_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    // Combinational read of the head: sees the pre-edge contents even if the same slot is written.
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Occupancy next-state
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/dbg_uart_tx.sv
// Debug word sink: buffers 16-bit words and sends each as two 8N1 bytes, high byte first.
module dbg_uart_tx
    import dbg_uart_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV = 104,
    parameter int unsigned DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] dbg_data,
    output logic        dbg_empty,
    output logic        tx,
    output logic        overflow
);

    localparam int unsigned TW = $clog2(CLK_DIV);
    localparam logic [TW-1:0] TMAX = TW'(CLK_DIV - 1);

    uart_state_e state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    idx_q, idx_d;
    logic [15:0]   hold_q, hold_d;
    logic          hi_sel_q, hi_sel_d;
    logic          tx_q, tx_d;
    logic          overflow_q;

    logic                  push, pop, bit_done;
    logic [15:0]           fifo_dout;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                  fifo_full, fifo_empty;
    logic [7:0]            byte_d;

    assign push     = (dbg_data != '0);
    assign bit_done = (timer_q == TMAX);

    dbg_fifo #(
        .WIDTH (16),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (dbg_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Serializer next-state, pop strobe and next line level
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        hi_sel_d = hi_sel_q;
        pop      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    hold_d   = fifo_dout;
                    hi_sel_d = 1'b1;
                    timer_d  = '0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (bit_done) begin
                    timer_d = '0;
                    idx_d   = '0;
                    state_d = StData;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StData: begin
                if (bit_done) begin
                    timer_d = '0;
                    if (idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StStop: begin
                if (bit_done) begin
                    timer_d = '0;
                    if (hi_sel_q) begin
                        hi_sel_d = 1'b0;
                        state_d  = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level is registered from next-state so tx never glitches
        byte_d = hi_sel_d ? hold_d[15:8] : hold_d[7:0];
        unique case (state_d)
            StStart: tx_d = START_BIT;
            StData:  tx_d = byte_d[idx_d];
            default: tx_d = STOP_BIT;
        endcase
    end

    // Serializer state, line and sticky overflow registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            idx_q      <= '0;
            hold_q     <= '0;
            hi_sel_q   <= 1'b0;
            tx_q       <= STOP_BIT;
            overflow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            hold_q   <= hold_d;
            hi_sel_q <= hi_sel_d;
            tx_q     <= tx_d;
            if (push && fifo_full && !pop) overflow_q <= 1'b1;
        end
    end

    assign dbg_empty = (fifo_count == '0) && (state_q == StIdle);
    assign tx        = tx_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_dbg_uart_tx.sv
// Scoreboard bench for dbg_uart_tx: word-level timing model plus a UART byte decoder.
module tb_dbg_uart_tx;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned FRAME   = 20 * CLK_DIV;  // line-active cycles per word
    localparam int unsigned BYTE_T  = 10 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] dbg_data = '0;
    logic        dbg_empty, tx, overflow;

    int n_cmp = 0;
    int n_fail = 0;

    dbg_uart_tx #(
        .CLK_DIV (CLK_DIV),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dbg_data  (dbg_data),
        .dbg_empty (dbg_empty),
        .tx        (tx),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Reference model state: queued words, remaining frame cycles, word on the line
    logic [15:0] mq[$];
    logic [7:0]  exp_bytes[$];
    int          busy = 0;
    logic [15:0] cur = '0;
    logic        m_ovf = 1'b0;
    logic        mvalid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_tx();
        int e, bsel, b;
        logic [7:0] v;
        if (busy == 0) return 1'b1;
        e    = FRAME - busy;
        bsel = e / BYTE_T;
        b    = (e % BYTE_T) / CLK_DIV;
        v    = (bsel == 0) ? cur[15:8] : cur[7:0];
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return v[b-1];
    endfunction

    // Model update on each active edge
    initial begin
        logic p;
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                exp_bytes.delete();
                busy   = 0;
                m_ovf  = 1'b0;
                mvalid = 1'b1;
            end else begin
                p = (busy == 0) && (mq.size() > 0);
                if (dbg_data != 16'h0) begin
                    if (mq.size() < DEPTH || p) begin
                        mq.push_back(dbg_data);
                        exp_bytes.push_back(dbg_data[15:8]);
                        exp_bytes.push_back(dbg_data[7:0]);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                if (p) begin
                    cur  = mq.pop_front();
                    busy = FRAME;
                end else if (busy > 0) begin
                    busy--;
                end
            end
        end
    end

    // Per-cycle output checks against the model
    initial begin
        forever begin
            @(negedge clk);
            if (mvalid) begin
                chk("tx", tx, exp_tx());
                chk("dbg_empty", dbg_empty, (mq.size() == 0) && (busy == 0));
                chk("overflow", overflow, m_ovf);
            end
        end
    end

    // Monitor: decode UART bytes at mid-bit and pop expected bytes from the scoreboard
    initial begin
        bit         dact = 0;
        int         dcnt = 0;
        int         k;
        logic [7:0] dbyte = '0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst || !mvalid) begin
                dact = 0;
            end else begin
                if (!dact) begin
                    if (tx === 1'b0) begin
                        dact = 1;
                        dcnt = 0;
                    end
                end else begin
                    dcnt++;
                end
                if (dact && (dcnt % CLK_DIV) == CLK_DIV / 2) begin
                    k = dcnt / CLK_DIV;
                    if (k == 0) begin
                        chk("start_bit", tx, 1'b0);
                    end else if (k <= 8) begin
                        dbyte[k-1] = tx;
                    end else begin
                        chk("stop_bit", tx, 1'b1);
                        dact = 0;
                        if (exp_bytes.size() == 0) begin
                            n_cmp++;
                            n_fail++;
                            $display("FAIL unexpected_byte: got %0h expected none", dbyte);
                        end else begin
                            e = exp_bytes.pop_front();
                            chk("byte", dbyte, e);
                        end
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            if (mq.size() == 0 && busy == 0 && dbg_empty === 1'b1) break;
            cyc(1);
        end
        if (i == limit) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_idle: timeout got busy %0d expected 0", busy);
        end
    endtask

    task automatic wait_busy(input int v, input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            if (busy == v) break;
            cyc(1);
        end
        if (i == limit) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_busy: timeout got %0d expected %0d", busy, v);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        cyc(n);
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] burst [3];
        int          ovf_pre;
        burst[0] = 16'h4001;
        burst[1] = 16'h2EA4;
        burst[2] = 16'h2105;

        // Reset then quiet line
        #2;
        cyc(3);
        rst = 1'b0;
        chk("reset_tx", tx, 1'b1);
        chk("reset_empty", dbg_empty, 1'b1);
        chk("reset_ovf", overflow, 1'b0);
        cyc(100);

        // Single word, latency checked cycle by cycle against the model
        dbg_data = 16'h4012;
        cyc(1);
        dbg_data = '0;
        chk("single_empty_low", dbg_empty, 1'b0);
        wait_idle(300);
        cyc(10);

        // Halt burst on consecutive cycles
        foreach (burst[i]) begin
            dbg_data = burst[i];
            cyc(1);
        end
        dbg_data = '0;
        wait_idle(600);
        chk("burst_no_ovf", overflow, 1'b0);
        chk("burst_drained", exp_bytes.size(), 0);

        // Overflow: six distinct words back to back while idle
        for (int i = 0; i < 6; i++) begin
            dbg_data = 16'h1000 + 16'(i * 16'h0111) + 16'h1;
            cyc(1);
        end
        dbg_data = '0;
        chk("ovf_set", overflow, 1'b1);
        wait_idle(1000);
        cyc(20);
        chk("ovf_sticky", overflow, 1'b1);
        do_reset(1);
        chk("ovf_cleared", overflow, 1'b0);

        // Fill during low-byte STOP, then push on the pop edge of a full FIFO
        dbg_data = 16'h55AA;
        cyc(1);
        dbg_data = '0;
        wait_busy(DEPTH, 200);
        for (int i = 0; i <= DEPTH; i++) begin
            dbg_data = 16'($urandom_range(1, 65535));
            cyc(1);
        end
        dbg_data = '0;
        chk("full_pop_no_ovf", overflow, 1'b0);
        wait_idle(1000);

        // Randomized traffic
        do_reset(1);
        for (int i = 0; i < 600; i++) begin
            dbg_data = ($urandom_range(0, 99) < 3) ? 16'($urandom_range(1, 65535)) : 16'h0;
            cyc(1);
        end
        dbg_data = '0;
        wait_idle(2000);
        chk("rand_drained", exp_bytes.size(), 0);

        // Reset in the middle of the second byte's data bits
        do_reset(1);
        dbg_data = 16'hC3A5;
        cyc(1);
        dbg_data = '0;
        wait_busy(FRAME - (BYTE_T + 3 * CLK_DIV), 200);
        ovf_pre = n_fail;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("midreset_tx", tx, 1'b1);
        chk("midreset_empty", dbg_empty, 1'b1);
        cyc(200);
        chk("midreset_quiet", tx, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
